level_receiver: RTL and testbench
=================================

// Module: level_receiver
// PURPOSE
//  Receive end of the positive-level driver interface. Takes up to CHANNELS
//  active-low line levels from an external cable or backplane and conditions
//  each one for the rest of the design. Each channel is synchronised, then
//  deglitched, and finally presented as a clean logic level plus one-cycle
//  rise and fall pulses.
//  Sits between the I/O connector pins and the internal IOT / flag logic.
// PARAMETERS
//  CHANNELS     3   number of independent line channels
//  SYNC_STAGES  2   synchroniser depth (flops), >=2
//  FILTER_W     4   width of per-channel stability counter
//  FILTER_CNT   10  consecutive synced cycles required to accept a change,
//                   1..2**FILTER_W-1
//  INVERT       1   1: line low = logic 1 (driver NAND output); 0: no inversion
// PORTS
//  clk         in   1         system clock; single clock domain
//  rst_n       in   1         asynchronous, active-low reset
//  line_in     in   CHANNELS  raw external line levels, asynchronous to clk
//  filt_en     in   1         1: deglitch filter active; 0: bypass filter
//  level_out   out  CHANNELS  conditioned logic level per channel
//  rise_pulse  out  CHANNELS  1-cycle pulse when level_out goes 0->1
//  fall_pulse  out  CHANNELS  1-cycle pulse when level_out goes 1->0
//  any_change  out  1         OR of all rise_pulse and fall_pulse bits, same cycle
// BEHAVIOUR
//  - Reset (rst_n=0, asynchronous): level_out=0, rise_pulse=0, fall_pulse=0,
//    any_change=0, all counters=0.
//  - On reset, synchroniser flops load the idle line value: 1 if INVERT=1,
//    else 0. Release of reset therefore never produces a pulse.
//  - Logic sample s = INVERT ? ~sync_out : sync_out, where sync_out is the
//    last synchroniser stage.
//  - Filtered mode (filt_en=1), per channel, evaluated at each clk edge:
//    - s == level_out: counter cleared to 0.
//    - s != level_out and counter < FILTER_CNT-1: counter increments.
//    - s != level_out and counter == FILTER_CNT-1: level_out <= s,
//      counter <= 0, and the matching rise/fall pulse is high for that
//      cycle only.
//  - Latency, filtered: SYNC_STAGES+FILTER_CNT edges from a stable input
//    change to the level_out change.
//  - Glitch rejection: any excursion shorter than FILTER_CNT synced cycles
//    leaves level_out unchanged and produces no pulse.
//  - Bypass mode (filt_en=0): level_out <= s every edge and counter held at 0.
//    Latency is SYNC_STAGES+1 edges. Pulses are still generated on every change.
//  - filt_en may change at any time. On the 1->0 transition the counter
//    clears. On 0->1, counting starts from 0 on the next mismatch.
//  - FILTER_CNT=1 behaves identically to bypass mode.
//  - Pulses are registered outputs asserted in the same cycle as the
//    level_out update. rise_pulse and fall_pulse on one channel are never
//    both high.
//  - Channels are fully independent: simultaneous changes on several
//    channels give simultaneous pulses, and any_change=1 for that one cycle.
//  - Reset asserted mid-count aborts the count. level_out returns to 0
//    immediately, with no pulse.
// STRUCTURE
//  - Package level_rx_pkg holds the default constants (SYNC_STAGES,
//    FILTER_W, FILTER_CNT) and the function idle_level(INVERT).
//  - One sub-module, level_rx_chan, implements a single channel:
//    synchroniser, counter, level flop and pulse flops.
//  - The top instantiates CHANNELS copies in a generate loop and forms
//    any_change as the OR-reduction of all pulses.
// TESTING
//  1. Reset, INVERT=1, line_in=3'b111 held 20 cycles -> level_out=000,
//     no pulses, any_change never 1.
//  2. filt_en=1, drop line_in[0] to 0 and hold -> level_out[0]=1 exactly
//     12 edges later; rise_pulse[0] high 1 cycle; any_change=1 that cycle.
//  3. filt_en=1, low glitch of 5 cycles on line_in[1] -> level_out[1]
//     stays 0, no pulse; a repeat glitch of 11 cycles is accepted.
//  4. filt_en=0, toggle line_in[2] every 4 cycles -> level_out[2] follows
//     with a 3-edge lag; alternating rise/fall pulses, one per toggle.
//  5. All three lines fall in the same cycle, filt_en=1 -> all rise_pulse
//     bits high in the same cycle; any_change high for exactly 1 cycle.
//  6. Assert rst_n=0 at count=7 after level_out[0]=1 -> level_out=0
//     asynchronously, no fall_pulse; after release with the line still low,
//     rise_pulse[0] follows 12 edges later.

Source files
------------

// File: rtl/level_rx_pkg.sv
// Shared defaults and helpers for the level receiver channels.
package level_rx_pkg;

    localparam int unsigned DEFAULT_SYNC_STAGES = 2;
    localparam int unsigned DEFAULT_FILTER_W    = 4;
    localparam int unsigned DEFAULT_FILTER_CNT  = 10;

    typedef enum logic [1:0] {
        EDGE_NONE = 2'b00,
        EDGE_RISE = 2'b01,
        EDGE_FALL = 2'b10
    } edge_t;

    // Resting line level: a NAND-driven line idles high.
    function automatic logic idle_level(input bit invert);
        return invert ? 1'b1 : 1'b0;
    endfunction

endpackage

// File: rtl/level_rx_chan.sv
// One receive channel: synchroniser, stability counter, level flop and edge pulses.
module level_rx_chan
    import level_rx_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = DEFAULT_SYNC_STAGES,
    parameter int unsigned FILTER_W    = DEFAULT_FILTER_W,
    parameter int unsigned FILTER_CNT  = DEFAULT_FILTER_CNT,
    parameter bit          INVERT      = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic line_in,
    input  logic filt_en,
    output logic level_out,
    output logic rise_pulse,
    output logic fall_pulse
);

    localparam logic                IDLE     = idle_level(INVERT);
    localparam logic [FILTER_W-1:0] CNT_LAST = FILTER_W'(FILTER_CNT - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sample;
    logic [FILTER_W-1:0]    cnt_q;
    logic [FILTER_W-1:0]    cnt_d;
    logic                   level_d;
    edge_t                  edge_d;

    // Synchroniser resets to the idle line value so reset release is silent.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{IDLE}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], line_in};
        end
    end

    always_comb begin
        sample = INVERT ? ~sync_q[SYNC_STAGES-1] : sync_q[SYNC_STAGES-1];
    end

    always_comb begin
        cnt_d   = '0;
        level_d = level_out;
        edge_d  = EDGE_NONE;
        if (!filt_en) begin
            level_d = sample;
        end else if (sample != level_out) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sample;
            end else begin
                cnt_d = cnt_q + FILTER_W'(1);
            end
        end
        if (level_d && !level_out) begin
            edge_d = EDGE_RISE;
        end else if (!level_d && level_out) begin
            edge_d = EDGE_FALL;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            level_out  <= 1'b0;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            level_out  <= level_d;
            rise_pulse <= (edge_d == EDGE_RISE);
            fall_pulse <= (edge_d == EDGE_FALL);
        end
    end

endmodule

// File: rtl/level_receiver.sv
// Receive end of the positive-level driver interface: CHANNELS independent
// conditioned line levels with rise/fall pulses and a combined change flag.
module level_receiver
    import level_rx_pkg::*;
#(
    parameter int unsigned CHANNELS    = 3,
    parameter int unsigned SYNC_STAGES = DEFAULT_SYNC_STAGES,
    parameter int unsigned FILTER_W    = DEFAULT_FILTER_W,
    parameter int unsigned FILTER_CNT  = DEFAULT_FILTER_CNT,
    parameter bit          INVERT      = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] line_in,
    input  logic                filt_en,
    output logic [CHANNELS-1:0] level_out,
    output logic [CHANNELS-1:0] rise_pulse,
    output logic [CHANNELS-1:0] fall_pulse,
    output logic                any_change
);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        level_rx_chan #(
            .SYNC_STAGES (SYNC_STAGES),
            .FILTER_W    (FILTER_W),
            .FILTER_CNT  (FILTER_CNT),
            .INVERT      (INVERT)
        ) u_chan (
            .clk        (clk),
            .rst_n      (rst_n),
            .line_in    (line_in[i]),
            .filt_en    (filt_en),
            .level_out  (level_out[i]),
            .rise_pulse (rise_pulse[i]),
            .fall_pulse (fall_pulse[i])
        );
    end

    always_comb begin
        any_change = |{rise_pulse, fall_pulse};
    end

endmodule

// File: tb/tb_level_receiver.sv
// Scoreboard bench for level_receiver: a delay-line/streak reference model
// pushes expected outputs per edge; a negedge monitor pops and compares.
module tb_level_receiver;

    localparam int unsigned CH   = 3;
    localparam int unsigned SYNC = 2;
    localparam int unsigned FCNT = 10;
    localparam bit          INV  = 1'b1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          filt_en;
    logic [CH-1:0] line_in;
    logic [CH-1:0] level_out;
    logic [CH-1:0] rise_pulse;
    logic [CH-1:0] fall_pulse;
    logic          any_change;

    always #5 clk = ~clk;

    level_receiver #(
        .CHANNELS    (CH),
        .SYNC_STAGES (SYNC),
        .FILTER_W    (4),
        .FILTER_CNT  (FCNT),
        .INVERT      (INV)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .line_in    (line_in),
        .filt_en    (filt_en),
        .level_out  (level_out),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse),
        .any_change (any_change)
    );

    typedef struct {
        logic [CH-1:0] level;
        logic [CH-1:0] rise;
        logic [CH-1:0] fall;
        logic          any;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string name, input logic [CH-1:0] act, input logic [CH-1:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, req);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, req);
        end
    endtask

    // Reference model: a SYNC-deep delay line per channel, then acceptance once
    // FCNT consecutive filtered samples disagree with the current level.
    logic          m_pipe[CH][$];
    logic [CH-1:0] m_level;
    int            m_streak[CH];
    exp_t          m_e;

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            m_pipe[c].delete();
            for (int k = 0; k < SYNC; k++) m_pipe[c].push_back(INV);
            m_streak[c] = 0;
        end
        m_level = '0;
    endtask

    always @(posedge clk) begin
        if (!rst_n) begin
            model_reset();
        end else begin
            logic [CH-1:0] nxt;
            logic          s;
            nxt = m_level;
            for (int c = 0; c < CH; c++) begin
                s = m_pipe[c].pop_front() ^ INV;
                m_pipe[c].push_back(line_in[c]);
                if (!filt_en) begin
                    nxt[c] = s;
                    m_streak[c] = 0;
                end else if (s != m_level[c]) begin
                    m_streak[c]++;
                    if (m_streak[c] >= FCNT) begin
                        nxt[c] = s;
                        m_streak[c] = 0;
                    end
                end else begin
                    m_streak[c] = 0;
                end
            end
            m_e.level = nxt;
            m_e.rise  = nxt & ~m_level;
            m_e.fall  = ~nxt & m_level;
            m_e.any   = (nxt != m_level);
            m_level   = nxt;
            exp_q.push_back(m_e);
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
        end else if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("level_out", level_out, e.level);
            chk("rise_pulse", rise_pulse, e.rise);
            chk("fall_pulse", fall_pulse, e.fall);
            chk("any_change", {2'b00, any_change}, {2'b00, e.any});
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Edges until level_out[ch] rises, -1 if it never does within the budget.
    task automatic measure(input int ch, output int n);
        bit found;
        n = 0;
        found = 1'b0;
        while (n < 40 && !found) begin
            @(posedge clk);
            #2;
            n++;
            if (level_out[ch]) found = 1'b1;
        end
        if (!found) n = -1;
    endtask

    initial begin
        int n;
        rst_n   = 1'b0;
        filt_en = 1'b1;
        line_in = 3'b111;
        cycles(3);
        rst_n = 1'b1;

        cycles(20);
        chk("idle_level", level_out, 3'b000);

        line_in[0] = 1'b0;
        measure(0, n);
        chk_int("filtered_latency", n, SYNC + FCNT);

        line_in[1] = 1'b0;
        cycles(5);
        line_in[1] = 1'b1;
        cycles(20);
        chk("glitch_rejected", level_out, 3'b001);
        line_in[1] = 1'b0;
        cycles(11);
        line_in[1] = 1'b1;
        cycles(30);

        filt_en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            line_in[2] = ~line_in[2];
            cycles(4);
        end
        cycles(10);
        filt_en = 1'b1;

        line_in = 3'b111;
        cycles(30);
        chk("all_idle", level_out, 3'b000);
        line_in = 3'b000;
        cycles(20);
        chk("all_active", level_out, 3'b111);

        cycles(7);
        rst_n = 1'b0;
        #1;
        chk("async_rst_level", level_out, 3'b000);
        chk("async_rst_fall", fall_pulse, 3'b000);
        chk("async_rst_any", {2'b00, any_change}, 3'b000);
        cycles(2);
        rst_n = 1'b1;
        measure(0, n);
        chk_int("post_reset_latency", n, SYNC + FCNT);
        cycles(5);

        repeat (60) begin
            line_in = 3'($urandom);
            if ($urandom_range(0, 7) == 0) filt_en = ~filt_en;
            if ($urandom_range(0, 29) == 0) begin
                rst_n = 1'b0;
                cycles(2);
                rst_n = 1'b1;
            end
            cycles($urandom_range(1, 14));
        end
        filt_en = 1'b1;
        cycles(20);

        @(negedge clk);
        #1;
        chk_int("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
